// File: rtl/motoro3_step_sequencer.sv
// Six-step motor commutation sequencer: walks sgStep 0..11 with a per-step down-counter,
// emits step-edge strobes, counts revolutions and supports graceful-stop and fault abort.
module motoro3_step_sequencer #(
    parameter logic [24:0] STEP_MIN = 25'd8,
    parameter int unsigned ROUND_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               fault,
    input  logic [24:0]        m3r_stepLen,
    output logic [3:0]         sgStep,
    output logic [24:0]        m3cnt,
    output logic               m3cntFirst2,
    output logic               m3cntFirst1,
    output logic               m3cntLast2,
    output logic               m3cntLast1,
    output logic               pwmActive1,
    output logic               pwmLastStep1,
    output logic [ROUND_W-1:0] roundCnt,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [3:0] LAST_STEP = 4'd11;

    state_e               state_q, state_d;
    logic [24:0]          len_q, len_d;
    logic [24:0]          cnt_q, cnt_d;
    logic [3:0]           sg_q, sg_d;
    logic                 stop_req_q, stop_req_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic [24:0]          len_clamped;
    logic                 active;

    assign len_clamped = (m3r_stepLen < STEP_MIN) ? STEP_MIN : m3r_stepLen;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= STEP_MIN;
            cnt_q      <= '0;
            sg_q       <= '0;
            stop_req_q <= 1'b0;
            round_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            sg_q       <= sg_d;
            stop_req_q <= stop_req_d;
            round_q    <= round_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        sg_d       = sg_q;
        stop_req_d = stop_req_q;
        round_d    = round_q;
        if (fault) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            sg_d       = '0;
            stop_req_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_LOAD;
                        round_d = '0;
                    end
                end
                ST_LOAD: begin
                    len_d   = len_clamped;
                    cnt_d   = len_clamped - 25'd1;
                    sg_d    = '0;
                    state_d = ST_RUN;
                end
                ST_RUN, ST_DRAIN: begin
                    if (state_q == ST_RUN && stop) begin
                        stop_req_d = 1'b1;
                    end
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 25'd1;
                    end else begin
                        // Step boundary: the only point where a new step length is taken.
                        len_d = len_clamped;
                        cnt_d = len_clamped - 25'd1;
                        sg_d  = (sg_q == LAST_STEP) ? 4'd0 : sg_q + 4'd1;
                        if (sg_q == LAST_STEP) begin
                            round_d = round_q + ROUND_W'(1);
                            if (state_q == ST_DRAIN) begin
                                state_d    = ST_IDLE;
                                cnt_d      = '0;
                                stop_req_d = 1'b0;
                            end else if (stop_req_q || stop) begin
                                state_d = ST_DRAIN;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        active       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        m3cntFirst2  = active && (cnt_q == len_q - 25'd1);
        m3cntFirst1  = active && (cnt_q == len_q - 25'd2);
        m3cntLast2   = active && (cnt_q == 25'd1);
        m3cntLast1   = active && (cnt_q == 25'd0);
        pwmActive1   = active;
        pwmLastStep1 = (state_q == ST_DRAIN) && (sg_q == LAST_STEP);
        busy         = (state_q != ST_IDLE);
    end

    assign sgStep   = sg_q;
    assign m3cnt    = cnt_q;
    assign roundCnt = round_q;

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Self-checking bench for motoro3_step_sequencer: a cycle model feeds a scoreboard queue,
// a vector table covers reset/run/clamp/priority, hand sequences cover multi-cycle corners.
module tb_motoro3_step_sequencer;

  localparam int RW       = 3;
  localparam int STEP_MIN = 8;

  logic clk = 1'b0;
  always #50 clk = ~clk;  // 10 MHz

  logic          rst, start, stop, fault;
  logic [24:0]   step_len;
  logic [3:0]    sgStep;
  logic [24:0]   m3cnt;
  logic          m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1;
  logic          pwmActive1, pwmLastStep1, busy;
  logic [RW-1:0] roundCnt;

  motoro3_step_sequencer #(.STEP_MIN(25'd8), .ROUND_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .fault(fault),
    .m3r_stepLen(step_len), .sgStep(sgStep), .m3cnt(m3cnt),
    .m3cntFirst2(m3cntFirst2), .m3cntFirst1(m3cntFirst1),
    .m3cntLast2(m3cntLast2), .m3cntLast1(m3cntLast1),
    .pwmActive1(pwmActive1), .pwmLastStep1(pwmLastStep1),
    .roundCnt(roundCnt), .busy(busy)
  );

  typedef struct packed {
    logic [3:0]    sg;
    logic [24:0]   cnt;
    logic          f2, f1, l2, l1, pwm, last, busy;
    logic [RW-1:0] round;
  } obs_t;

  obs_t act;
  assign act = {sgStep, m3cnt, m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1,
                pwmActive1, pwmLastStep1, busy, roundCnt};

  int   n_cmp  = 0;
  int   n_fail = 0;
  obs_t exp_q[$];

  // Reference model: 0 idle, 1 load, 2 run, 3 drain
  int m_state = 0, m_len = STEP_MIN, m_cnt = 0, m_sg = 0, m_round = 0;
  bit m_stop  = 1'b0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
    n_cmp++;
    if (actual !== required) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  task automatic model_next();
    int cl;
    bit stop_now;
    cl = (step_len < 25'(STEP_MIN)) ? STEP_MIN : int'(step_len);
    if (rst) begin
      m_state = 0; m_sg = 0; m_cnt = 0; m_len = STEP_MIN; m_stop = 1'b0; m_round = 0;
    end else if (fault) begin
      m_state = 0; m_sg = 0; m_cnt = 0; m_stop = 1'b0;
    end else begin
      case (m_state)
        0: if (start) begin m_state = 1; m_round = 0; end
        1: begin m_len = cl; m_cnt = cl - 1; m_sg = 0; m_state = 2; end
        default: begin
          stop_now = m_stop || (m_state == 2 && stop);
          if (m_state == 2 && stop) m_stop = 1'b1;
          if (m_cnt > 0) m_cnt--;
          else if (m_sg < 11) begin m_sg++; m_len = cl; m_cnt = cl - 1; end
          else begin
            m_round = (m_round + 1) % (1 << RW);
            if (m_state == 3) begin
              m_state = 0; m_sg = 0; m_cnt = 0; m_stop = 1'b0;
            end else begin
              m_sg = 0; m_len = cl; m_cnt = cl - 1;
              if (stop_now) m_state = 3;
            end
          end
        end
      endcase
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    bit   a;
    a       = (m_state >= 2);
    o.sg    = 4'(m_sg);
    o.cnt   = 25'(m_cnt);
    o.f2    = a && (m_cnt == m_len - 1);
    o.f1    = a && (m_cnt == m_len - 2);
    o.l2    = a && (m_cnt == 1);
    o.l1    = a && (m_cnt == 0);
    o.pwm   = a;
    o.last  = (m_state == 3) && (m_sg == 11);
    o.busy  = (m_state != 0);
    o.round = RW'(m_round);
    return o;
  endfunction

  // One clock: predict, push, clock, pop and compare on the falling edge.
  task automatic tick();
    model_next();
    exp_q.push_back(model_obs());
    @(posedge clk);
    @(negedge clk);
    check("scoreboard", act, exp_q.pop_front());
    check("strobe_excl", $countones({m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1}) <= 1, 1);
  endtask

  task automatic step_meas(output int cycles);
    logic [3:0] s0;
    s0     = sgStep;
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (sgStep == s0 && cycles < 200);
  endtask

  typedef struct {
    bit rst, start, stop, fault;
    int len, cycles, sg, cnt;
    bit busy, pwm;
    int round;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int n, m, nlast;
    //            rst st sp ft len cyc sg cnt busy pwm round
    vecs[0]  = '{1, 0, 0, 0, 20,   2, 0,  0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 20,   1, 0,  0, 1, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 20,   1, 0, 19, 1, 1, 0};
    vecs[3]  = '{0, 0, 0, 0, 20,  20, 1, 19, 1, 1, 0};
    vecs[4]  = '{0, 0, 0, 0, 20, 220, 0, 19, 1, 1, 1};
    vecs[5]  = '{0, 1, 0, 0, 20,   1, 0, 18, 1, 1, 1};
    vecs[6]  = '{0, 0, 0, 1, 20,   1, 0,  0, 0, 0, 1};
    vecs[7]  = '{0, 1, 0, 1, 20,   1, 0,  0, 0, 0, 1};
    vecs[8]  = '{0, 1, 0, 0,  3,   1, 0,  0, 1, 0, 0};
    vecs[9]  = '{0, 0, 0, 0,  3,   1, 0,  7, 1, 1, 0};
    vecs[10] = '{0, 0, 0, 0,  3,   8, 1,  7, 1, 1, 0};
    vecs[11] = '{0, 0, 0, 0,  3,  88, 0,  7, 1, 1, 1};
    vecs[12] = '{1, 0, 0, 0,  3,   1, 0,  0, 0, 0, 0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; fault = 1'b0; step_len = 25'd20;

    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop; fault = vecs[i].fault;
      step_len = 25'(vecs[i].len);
      for (int c = 0; c < vecs[i].cycles; c++) tick();
      check($sformatf("vec%0d_sg", i), sgStep, vecs[i].sg);
      check($sformatf("vec%0d_cnt", i), m3cnt, vecs[i].cnt);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d_pwm", i), pwmActive1, vecs[i].pwm);
      check($sformatf("vec%0d_round", i), roundCnt, vecs[i].round);
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; fault = 1'b0;

    // Step-length change mid step 4 only affects step 5
    step_len = 25'd20; start = 1'b1; tick(); start = 1'b0; tick();
    check("basic_first2", m3cntFirst2, 1);
    tick();
    check("basic_first1", m3cntFirst1, 1);
    n = 0;
    while (sgStep != 4'd4 && n < 200) begin tick(); n++; end
    check("reach_step4", n < 200, 1);
    repeat (5) tick();
    step_len = 25'd30;
    step_meas(m);
    check("step4_len", 5 + m, 20);
    step_meas(m);
    check("step5_len", m, 30);

    // Graceful stop during step 7
    step_len = 25'd20;
    n = 0;
    while (sgStep != 4'd7 && n < 200) begin tick(); n++; end
    check("reach_step7", n < 200, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    n = 0; nlast = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
      if (pwmLastStep1) nlast++;
    end
    check("drain_done", n < 1000, 1);
    check("drain_last_cycles", nlast, 20);
    check("stop_round", roundCnt, 2);
    check("stop_pwm_off", pwmActive1, 0);
    check("stop_idle_cnt", m3cnt, 0);

    // Fault at step 5, m3cnt 9 of the second revolution
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(roundCnt == 1 && sgStep == 4'd5 && m3cnt == 25'd9) && n < 600) begin tick(); n++; end
    check("reach_fault_point", n < 600, 1);
    fault = 1'b1; tick(); fault = 1'b0;
    check("fault_busy", busy, 0);
    check("fault_sg", sgStep, 0);
    check("fault_cnt", m3cnt, 0);
    check("fault_strobes", {m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1, pwmActive1}, 0);
    check("fault_round", roundCnt, 1);
    tick();
    check("idle_round_hold", roundCnt, 1);

    // Revolution counter wrap with clamped steps of 8 clocks
    step_len = 25'd3; start = 1'b1; tick(); start = 1'b0; tick();
    repeat (96 * 7) tick();
    check("round_all_ones", roundCnt, 7);
    repeat (96) tick();
    check("round_wrap", roundCnt, 0);
    check("wrap_busy", busy, 1);
    check("wrap_sg", sgStep, 0);
    check("wrap_cnt", m3cnt, 7);

    // Reset during DRAIN aborts at once
    stop = 1'b1; tick(); stop = 1'b0;
    n = 0;
    while (!pwmLastStep1 && n < 300) begin tick(); n++; end
    check("reach_drain", n < 300, 1);
    rst = 1'b1; fault = 1'b1; tick(); rst = 1'b0; fault = 1'b0;
    check("rst_drain_all", act, 0);
    tick();
    check("rst_drain_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
